// File: rtl/min_max_led_bar.sv
// Thermometer LED bar driver: windowed, linear and all-off/all-on test modes.
// Next pattern is purely combinational; leds_o is the only state.
module min_max_led_bar #(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              com_i,
    input  logic [VALSIZE-1:0]      max_i,
    input  logic [VALSIZE-1:0]      min_i,
    input  logic                    osc_i,
    input  logic [VALSIZE-1:0]      val_i,
    output logic [(2**VALSIZE)-1:0] leds_o
);

    localparam int NLEDS = 2 ** VALSIZE;

    localparam logic [1:0] COM_NORMAL = 2'b00;
    localparam logic [1:0] COM_LINEAR = 2'b01;
    localparam logic [1:0] COM_OFF    = 2'b10;
    localparam logic [1:0] COM_ON     = 2'b11;

    logic [NLEDS-1:0] leds_d, leds_q;
    logic             in_win;

    // ERRNO 1 excludes val == max from the window (fault injection only).
    always_comb begin
        if (ERRNO == 1) in_win = (min_i <= val_i) && (val_i < max_i);
        else            in_win = (min_i <= val_i) && (val_i <= max_i);
    end

    always_comb begin
        leds_d = '0;
        unique case (com_i)
            COM_NORMAL: begin
                if (in_win) begin
                    for (int i = 0; i < NLEDS; i++) begin
                        if (i >= int'(min_i) && i <= int'(val_i))
                            leds_d[i] = 1'b1;
                        else if (i > int'(val_i) && i <= int'(max_i))
                            leds_d[i] = osc_i;
                    end
                end
            end
            COM_LINEAR: begin
                for (int i = 0; i < NLEDS; i++)
                    leds_d[i] = (i <= int'(val_i));
            end
            COM_OFF: leds_d = '0;
            COM_ON:  leds_d = '1;
            default: leds_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) leds_q <= '0;
        else       leds_q <= leds_d;
    end

    assign leds_o = leds_q;

endmodule

// File: tb/tb_min_max_led_bar.sv
// Scoreboard bench for min_max_led_bar (VALSIZE=4): expectations are queued when
// inputs are driven and popped one cycle later when leds_o is sampled.
module tb_min_max_led_bar;

    localparam int VALSIZE = 4;
    localparam int NLEDS   = 2 ** VALSIZE;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       com_i = 2'b00;
    logic [3:0]       max_i = '0;
    logic [3:0]       min_i = '0;
    logic             osc_i = 1'b0;
    logic [3:0]       val_i = '0;
    logic [NLEDS-1:0] leds_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [NLEDS-1:0] sb[$];
    logic [NLEDS-1:0] exp_v;

    min_max_led_bar #(.VALSIZE(VALSIZE), .ERRNO(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .com_i(com_i), .max_i(max_i),
        .min_i(min_i), .osc_i(osc_i), .val_i(val_i), .leds_o(leds_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  com;
        logic [3:0]  mn;
        logic [3:0]  mx;
        logic [3:0]  v;
        logic        o;
        logic [15:0] exp;
    } vec_t;

    // Mask-based reference for the windowed rule.
    function automatic logic [15:0] ref_normal(int mn, int mx, int v, logic o);
        int ones, oscm;
        if (!(mn <= v && v <= mx)) return 16'h0000;
        ones = ((2 << v) - 1) & ~((1 << mn) - 1);
        oscm = ((2 << mx) - 1) & ~((2 << v) - 1);
        return 16'(ones | (o ? oscm : 0));
    endfunction

    task automatic drive(logic [1:0] c, logic [3:0] mn, logic [3:0] mx,
                         logic [3:0] v, logic o);
        com_i = c; min_i = mn; max_i = mx; val_i = v; osc_i = o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
        sb.push_back(16'h0000);
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL reset_initial got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        vec_t tbl[11];
        tbl[0]  = '{2'b00, 4'd3, 4'd12, 4'd8,  1'b1, 16'h1FF8};
        tbl[1]  = '{2'b00, 4'd3, 4'd12, 4'd8,  1'b0, 16'h01F8};
        tbl[2]  = '{2'b00, 4'd0, 4'd15, 4'd15, 1'b0, 16'hFFFF};
        tbl[3]  = '{2'b00, 4'd0, 4'd14, 4'd15, 1'b1, 16'h0000};
        tbl[4]  = '{2'b00, 4'd5, 4'd9,  4'd4,  1'b1, 16'h0000};
        tbl[5]  = '{2'b00, 4'd9, 4'd5,  4'd7,  1'b1, 16'h0000};
        tbl[6]  = '{2'b00, 4'd6, 4'd6,  4'd6,  1'b1, 16'h0040};
        tbl[7]  = '{2'b01, 4'd10, 4'd12, 4'd5, 1'b1, 16'h003F};
        tbl[8]  = '{2'b01, 4'd3, 4'd9,  4'd0,  1'b0, 16'h0001};
        tbl[9]  = '{2'b10, 4'd3, 4'd12, 4'd8,  1'b1, 16'h0000};
        tbl[10] = '{2'b11, 4'd9, 4'd5,  4'd2,  1'b0, 16'hFFFF};
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].com, tbl[k].mn, tbl[k].mx, tbl[k].v, tbl[k].o);
            sb.push_back(tbl[k].exp);
            @(posedge clk_i); #1;
            exp_v = sb.pop_front();
            total_cnt++;
            if (leds_o !== exp_v)
                $display("FAIL directed[%0d] got=%h exp=%h", k, leds_o, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_linear_full();
        drive(2'b01, 4'd7, 4'd2, 4'd15, 1'b0);
        sb.push_back(16'hFFFF);
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL linear_full got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_random_normal();
        int mn, mx, v;
        logic o;
        for (int k = 0; k < 200; k++) begin
            mn = $urandom_range(14, 0);
            mx = $urandom_range(15, mn + 1);
            v  = $urandom_range(mx, mn);
            o  = 1'($urandom_range(1, 0));
            drive(2'b00, 4'(mn), 4'(mx), 4'(v), o);
            sb.push_back(ref_normal(mn, mx, v, o));
            @(posedge clk_i); #1;
            exp_v = sb.pop_front();
            total_cnt++;
            if (leds_o !== exp_v)
                $display("FAIL random[%0d] min=%0d max=%0d val=%0d osc=%0d got=%h exp=%h",
                         k, mn, mx, v, o, leds_o, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        drive(2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
        sb.push_back(16'hFFFF);
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL pre_reset_on got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
        rst_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(16'h0000);
            @(posedge clk_i); #1;
            exp_v = sb.pop_front();
            total_cnt++;
            if (leds_o !== exp_v)
                $display("FAIL reset_hold[%0d] got=%h exp=%h", k, leds_o, exp_v);
            else pass_cnt++;
        end
        rst_i = 1'b0;
        sb.push_back(16'hFFFF);
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL post_reset_on got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        drive(2'b00, 4'd3, 4'd12, 4'd8, 1'b0);
        sb.push_back(16'h01F8);
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL latency_start got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
        val_i = 4'd4;
        sb.push_back(16'h0018);
        #2;
        total_cnt++;
        if (leds_o !== 16'h01F8) $display("FAIL latency_hold got=%h exp=%h", leds_o, 16'h01F8);
        else pass_cnt++;
        @(posedge clk_i); #1;
        exp_v = sb.pop_front();
        total_cnt++;
        if (leds_o !== exp_v) $display("FAIL latency_update got=%h exp=%h", leds_o, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_linear_full();
        test_random_normal();
        test_reset_midrun();
        test_latency();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
